// File: rtl/kernel_pr_write_back_burst_pkg.sv
// Shared types for the PageRank write-back burst stage: FSM states and AXI length type.
package kernel_pr_wb_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        AW   = 3'd1,
        W    = 3'd2,
        B    = 3'd3,
        DONE = 3'd4
    } wb_state_e;

    localparam int WB_MAX_BURST = 256;

    typedef logic [7:0] axi_len_t;

endpackage

// File: rtl/kernel_pr_write_back_burst_if.sv
// AXI4-style write channel (AW/W/B) between the write-back stage and memory.
interface kernel_pr_write_back_burst_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 32
);
    import kernel_pr_wb_pkg::*;

    logic                  awvalid;
    logic                  awready;
    logic [ADDR_WIDTH-1:0] awaddr;
    axi_len_t              awlen;
    logic                  wvalid;
    logic                  wready;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  wlast;
    logic                  bvalid;
    logic                  bready;

    modport master (
        output awvalid, awaddr, awlen, wvalid, wdata, wlast, bready,
        input  awready, wready, bvalid
    );

    modport slave (
        input  awvalid, awaddr, awlen, wvalid, wdata, wlast, bready,
        output awready, wready, bvalid
    );

endinterface

// File: rtl/kernel_pr_write_back_burst.sv
// PageRank write-back: pops a start token, drains num_words ranks from a FWFT FIFO as AXI write bursts.
// Optional WB_PERF_CNT_EN adds a saturating W-channel stall counter output.
//
// state | meaning
// IDLE  | waiting for a start token
// AW    | presenting burst address/length
// W     | streaming beats of the current burst
// B     | waiting for the burst write response
// DONE  | one-cycle ap_done pulse
module kernel_pr_write_back_burst #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 64,
    parameter int CNT_WIDTH  = 32,
    parameter int BURST_LEN  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_empty_n,
    output logic                  start_read,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]  num_words,
    input  logic                  data_empty_n,
    output logic                  data_read,
    input  logic [DATA_WIDTH-1:0] data_dout,
    kernel_pr_write_back_burst_if.master axi,
    output logic                  ap_done,
    output logic                  ap_idle
`ifdef WB_PERF_CNT_EN
    ,
    output logic [31:0]           stall_cycles
`endif
);
    import kernel_pr_wb_pkg::*;

    localparam int BEAT_W         = $clog2(WB_MAX_BURST) + 1;
    localparam int BYTES_PER_BEAT = DATA_WIDTH / 8;
    localparam logic [CNT_WIDTH-1:0] BURST_CNT = CNT_WIDTH'(BURST_LEN);

    wb_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CNT_WIDTH-1:0]  remaining_q, remaining_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic [BEAT_W-1:0]     burst_len;
    logic                  w_fire;

    // Burst length is recomputed from remaining, which only moves in B, so AW/W see a stable value.
    assign burst_len = (remaining_q < BURST_CNT) ? remaining_q[BEAT_W-1:0] : BEAT_W'(BURST_LEN);
    assign w_fire    = !reset && (state_q == W) && data_empty_n && axi.wready;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        beat_d      = beat_q;
        start_read  = 1'b0;
        data_read   = 1'b0;
        ap_done     = 1'b0;
        ap_idle     = 1'b0;
        axi.awvalid = 1'b0;
        axi.awaddr  = '0;
        axi.awlen   = '0;
        axi.wvalid  = 1'b0;
        axi.wdata   = '0;
        axi.wlast   = 1'b0;
        axi.bready  = 1'b0;

        // Outputs are forced quiet while reset is held so an abandoned job cannot fire a handshake.
        if (reset) begin
            ap_idle = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    ap_idle = 1'b1;
                    if (start_empty_n) begin
                        start_read  = 1'b1;
                        addr_d      = base_addr;
                        remaining_d = num_words;
                        beat_d      = '0;
                        state_d     = (num_words == '0) ? DONE : AW;
                    end
                end
                AW: begin
                    axi.awvalid = 1'b1;
                    axi.awaddr  = addr_q;
                    axi.awlen   = axi_len_t'(burst_len - BEAT_W'(1));
                    if (axi.awready) begin
                        beat_d  = '0;
                        state_d = W;
                    end
                end
                W: begin
                    axi.wvalid = data_empty_n;
                    axi.wdata  = data_dout;
                    axi.wlast  = (beat_q == burst_len - BEAT_W'(1));
                    data_read  = data_empty_n && axi.wready;
                    if (w_fire) begin
                        beat_d = beat_q + BEAT_W'(1);
                        if (axi.wlast) begin
                            state_d = B;
                        end
                    end
                end
                B: begin
                    axi.bready = 1'b1;
                    if (axi.bvalid) begin
                        remaining_d = remaining_q - CNT_WIDTH'(burst_len);
                        addr_d      = addr_q + ADDR_WIDTH'(burst_len) * ADDR_WIDTH'(BYTES_PER_BEAT);
                        state_d     = (remaining_q == CNT_WIDTH'(burst_len)) ? DONE : AW;
                    end
                end
                DONE: begin
                    ap_done = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            beat_q      <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            beat_q      <= beat_d;
        end
    end

`ifdef WB_PERF_CNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (start_read) begin
            stall_cycles_d = '0;
        end else if (!reset && (state_q == W) && !w_fire && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_kernel_pr_write_back_burst.sv
// Directed self-checking bench for kernel_pr_write_back_burst; define WB_PERF_CNT_EN to cover the stall counter.
module tb_kernel_pr_write_back_burst;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_empty_n = 1'b0;
    logic [63:0] base_addr = '0;
    logic [31:0] num_words = '0;
    wire         start_read;
    wire         data_empty_n;
    wire         data_read;
    wire  [31:0] data_dout;
    wire         ap_done;
    wire         ap_idle;
`ifdef WB_PERF_CNT_EN
    wire  [31:0] stall_cycles;
`endif

    kernel_pr_write_back_burst_if #(.ADDR_WIDTH(64), .DATA_WIDTH(32)) axi ();

    kernel_pr_write_back_burst #(
        .DATA_WIDTH(32), .ADDR_WIDTH(64), .CNT_WIDTH(32), .BURST_LEN(16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start_empty_n (start_empty_n),
        .start_read    (start_read),
        .base_addr     (base_addr),
        .num_words     (num_words),
        .data_empty_n  (data_empty_n),
        .data_read     (data_read),
        .data_dout     (data_dout),
        .axi           (axi.master),
        .ap_done       (ap_done),
        .ap_idle       (ap_idle)
`ifdef WB_PERF_CNT_EN
        ,
        .stall_cycles  (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave / FIFO model controls (main block writes these only)
    logic wready_r = 1'b1;
    logic aw_slow = 1'b0;
    logic toggle_mode = 1'b0;
    logic [31:0] mem [512];
    int wr_ptr = 0;

    // Monitor-owned state
    logic bvalid_r = 1'b0;
    logic gate = 1'b1;
    int rd_ptr = 0;
    logic [63:0] aw_addr_q [$];
    logic [7:0]  aw_len_q [$];
    logic [31:0] w_data_q [$];
    logic        w_last_q [$];
    int rd_cnt = 0, done_cnt = 0, sr_cnt = 0, wv_viol = 0, aw_unstable = 0;
    int b_cyc = 0, done_cyc = 0, sr_cyc = 0;

    assign axi.awready  = aw_slow ? (cyc % 3 == 0) : 1'b1;
    assign axi.wready   = wready_r;
    assign axi.bvalid   = bvalid_r;
    assign data_empty_n = gate && (rd_ptr != wr_ptr);
    assign data_dout    = mem[rd_ptr % 512];

    // Sample on the falling edge (after the main block drives), apply slave/FIFO updates after the rising edge.
    logic        aw_wait = 1'b0;
    logic [63:0] aw_addr_prev = '0;
    logic [7:0]  aw_len_prev = '0;
    always @(negedge clk) begin
        logic pop, bhs, wl;
        #2;
        pop = 1'b0; bhs = 1'b0; wl = 1'b0;
        if (!reset) begin
            if (aw_wait && (!axi.awvalid || axi.awaddr != aw_addr_prev || axi.awlen != aw_len_prev))
                aw_unstable++;
            aw_wait      = axi.awvalid && !axi.awready;
            aw_addr_prev = axi.awaddr;
            aw_len_prev  = axi.awlen;
            if (axi.awvalid && axi.awready) begin
                aw_addr_q.push_back(axi.awaddr);
                aw_len_q.push_back(axi.awlen);
            end
            if (axi.wvalid && axi.wready) begin
                w_data_q.push_back(axi.wdata);
                w_last_q.push_back(axi.wlast);
                wl = axi.wlast;
            end
            if (axi.wvalid && !data_empty_n) wv_viol++;
            if (data_read) begin rd_cnt++; pop = 1'b1; end
            if (axi.bvalid && axi.bready) begin bhs = 1'b1; b_cyc = cyc; end
            if (start_read) begin sr_cnt++; sr_cyc = cyc; end
            if (ap_done) begin done_cnt++; done_cyc = cyc; end
        end else begin
            aw_wait = 1'b0;
        end
        @(posedge clk);
        #1;
        if (pop) rd_ptr++;
        if (bhs) bvalid_r = 1'b0;
        if (wl) bvalid_r = 1'b1;
        if (reset) bvalid_r = 1'b0;
        gate = toggle_mode ? !gate : 1'b1;
    end

    int n_assert = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    int aw0, w0, rd0, done0, sr0, wv0, awu0;
    task automatic snap();
        aw0 = aw_addr_q.size(); w0 = w_data_q.size(); rd0 = rd_cnt; done0 = done_cnt;
        sr0 = sr_cnt; wv0 = wv_viol; awu0 = aw_unstable;
    endtask

    task automatic load(input int n, output int first);
        first = wr_ptr;
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr % 512] = 32'hC0DE_0000 + 32'(wr_ptr);
            wr_ptr++;
        end
    endtask

    task automatic start_job(input string tag, input logic [63:0] addr, input int n);
        logic got;
        got = 1'b0;
        @(negedge clk);
        base_addr = addr;
        num_words = 32'(n);
        start_empty_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (start_read) begin got = 1'b1; break; end
            @(negedge clk);
        end
        @(negedge clk);
        start_empty_n = 1'b0;
        check({tag, "_start_read"}, got, 1);
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int i = 0; i < budget && done_cnt == done0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check({tag, "_ap_done_pulses"}, done_cnt - done0, 1);
    endtask

    // Expected bursts: min(remaining,16) beats, address advancing 4 bytes per beat.
    task automatic check_job(input string tag, input logic [63:0] addr, input int n, input int first);
        int rem, len, k, nb;
        logic [63:0] a;
        rem = n; a = addr; k = 0;
        nb = (n + 15) / 16;
        check({tag, "_aw_count"}, aw_addr_q.size() - aw0, nb);
        check({tag, "_w_count"}, w_data_q.size() - w0, n);
        for (int j = 0; j < nb; j++) begin
            len = (rem < 16) ? rem : 16;
            if (aw0 + j < aw_addr_q.size()) begin
                check($sformatf("%s_awaddr%0d", tag, j), aw_addr_q[aw0 + j], a);
                check($sformatf("%s_awlen%0d", tag, j), aw_len_q[aw0 + j], len - 1);
            end
            for (int b = 0; b < len; b++) begin
                if (w0 + k < w_data_q.size()) begin
                    check($sformatf("%s_wdata%0d", tag, k), w_data_q[w0 + k], 32'hC0DE_0000 + 32'(first + k));
                    check($sformatf("%s_wlast%0d", tag, k), w_last_q[w0 + k], (b == len - 1));
                end
                k++;
            end
            rem -= len;
            a += 64'(len * 4);
        end
        check({tag, "_data_reads"}, rd_cnt - rd0, n);
        check({tag, "_wvalid_vs_empty"}, wv_viol - wv0, 0);
        check({tag, "_aw_stable"}, aw_unstable - awu0, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        logic [63:0] exp_addr [3];
        logic [7:0]  exp_len [3];
        logic got;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_idle_during", ap_idle, 1);
        check("rst_outs_during", {start_read, data_read, axi.awvalid, axi.wvalid, axi.wlast, axi.bready, ap_done}, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_idle_after", ap_idle, 1);
        check("rst_outs_after", {start_read, data_read, axi.awvalid, axi.wvalid, axi.wlast, axi.bready, ap_done}, 0);

        // 1) five words, one short burst, done one cycle after the B handshake
        load(5, first);
        snap();
        start_job("t1", 64'h2000, 5);
        wait_done("t1", 200);
        check_job("t1", 64'h2000, 5, first);
        check("t1_done_after_b", done_cyc, b_cyc + 1);

        // 2) forty words from 0x1000 with a slow AW ready
        aw_slow = 1'b1;
        load(40, first);
        snap();
        start_job("t2", 64'h1000, 40);
        wait_done("t2", 1000);
        check_job("t2", 64'h1000, 40, first);
        exp_addr = '{64'h1000, 64'h1040, 64'h1080};
        exp_len  = '{8'd15, 8'd15, 8'd7};
        for (int j = 0; j < 3; j++) begin
            if (aw0 + j < aw_addr_q.size()) begin
                check($sformatf("t2_hand_addr%0d", j), aw_addr_q[aw0 + j], exp_addr[j]);
                check($sformatf("t2_hand_len%0d", j), aw_len_q[aw0 + j], exp_len[j]);
            end
        end
        aw_slow = 1'b0;

        // 3) FIFO empty every other cycle
        toggle_mode = 1'b1;
        load(20, first);
        snap();
        start_job("t3", 64'h3000, 20);
        wait_done("t3", 1000);
        check_job("t3", 64'h3000, 20, first);
        toggle_mode = 1'b0;

        // 4) zero-length job
        snap();
        start_job("t4", 64'h3800, 0);
        wait_done("t4", 50);
        check("t4_pops", sr_cnt - sr0, 1);
        check("t4_done_after_pop", done_cyc, sr_cyc + 1);
        check("t4_no_aw", aw_addr_q.size() - aw0, 0);
        check("t4_no_w", w_data_q.size() - w0, 0);
        check("t4_no_reads", rd_cnt - rd0, 0);

        // 5) reset mid-W after three beats, then a clean job
        load(10, first);
        snap();
        start_job("t5", 64'h4000, 10);
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (w_data_q.size() - w0 >= 3) begin got = 1'b1; break; end
            @(negedge clk);
        end
        check("t5_reached_3_beats", got, 1);
        reset = 1'b1;
        #1;
        check("t5_rst_outs_during", {start_read, data_read, axi.awvalid, axi.wvalid, axi.bready, ap_done}, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("t5_idle_after_rst", ap_idle, 1);
        check("t5_outs_after_rst", {start_read, data_read, axi.awvalid, axi.wvalid, axi.wlast, axi.bready, ap_done}, 0);
        check("t5_beats_before_rst", w_data_q.size() - w0, 3);
        check("t5_reads_before_rst", rd_cnt - rd0, 3);
        wr_ptr = rd_ptr;
        load(3, first);
        snap();
        start_job("t5b", 64'h5000, 3);
        wait_done("t5b", 200);
        check_job("t5b", 64'h5000, 3, first);

`ifdef WB_PERF_CNT_EN
        // 6) wready held low for 7 W cycles
        load(4, first);
        snap();
        start_job("t6", 64'h6000, 4);
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (w_data_q.size() - w0 >= 1) begin got = 1'b1; break; end
            @(negedge clk);
        end
        check("t6_reached_beat", got, 1);
        wready_r = 1'b0;
        repeat (7) @(negedge clk);
        wready_r = 1'b1;
        wait_done("t6", 200);
        check_job("t6", 64'h6000, 4, first);
        check("t6_stall_cycles", stall_cycles, 7);
        snap();
        start_job("t6b", 64'h7000, 0);
        check("t6_stall_cleared", stall_cycles, 0);
        wait_done("t6b", 50);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
